// File: rtl/fp16_stream_extremum.sv
// Streaming FP16 max/min reduction: tracks the best value and its index over a
// packet and presents one result beat per packet.
module fp16_stream_extremum #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 8,
  parameter int FIND_MIN   = 0,
  parameter int TIE_LAST   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_index,
  output logic [IDX_W:0]        out_count,
  output logic                  out_overflow
);

  typedef enum logic [1:0] {EMPTY, ACCUM, HOLD} state_t;

  localparam logic [IDX_W:0] CNT_MAX = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

  state_t                  state, state_n;
  logic                    started;
  logic [DATA_WIDTH-1:0]   best, best_n;
  logic [IDX_W-1:0]        best_idx, idx_n;
  logic [IDX_W:0]          cnt, cnt_n;
  logic                    ovf, ovf_n;
  logic                    accept;
  logic                    better;
  logic [DATA_WIDTH-1:0]   in_key, best_key;

  // Map sign-magnitude onto an unsigned key: positives above negatives, and
  // negatives inverted so larger magnitude sorts lower (-0 lands just below +0).
  function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? {1'b0, ~v[DATA_WIDTH-2:0]} : {1'b1, v[DATA_WIDTH-2:0]};
  endfunction

  assign in_key   = order_key(in_data);
  assign best_key = order_key(best);

  always_comb begin
    better = 1'b0;
    if (FIND_MIN != 0) better = (in_key < best_key);
    else               better = (in_key > best_key);
    if ((TIE_LAST != 0) && (in_key == best_key)) better = 1'b1;
  end

  assign in_ready  = started && (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_n = state;
    best_n  = best;
    idx_n   = best_idx;
    cnt_n   = cnt;
    ovf_n   = ovf;
    case (state)
      EMPTY: begin
        if (accept) begin
          best_n  = in_data;
          idx_n   = '0;
          cnt_n   = CNT_ONE;
          ovf_n   = 1'b0;
          state_n = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (cnt == CNT_MAX) begin
            ovf_n = 1'b1;
          end else begin
            if (better) begin
              best_n = in_data;
              idx_n  = cnt[IDX_W-1:0];
            end
            cnt_n = cnt + CNT_ONE;
          end
          if (in_last) state_n = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_n = EMPTY;
      end
      default: state_n = EMPTY;
    endcase
  end

  // Result registers are captured only on entry to HOLD so they stay frozen
  // while the next packet accumulates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      started      <= 1'b0;
      best         <= '0;
      best_idx     <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_data     <= '0;
      out_index    <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      started  <= 1'b1;
      state    <= state_n;
      best     <= best_n;
      best_idx <= idx_n;
      cnt      <= cnt_n;
      ovf      <= ovf_n;
      if ((state != HOLD) && (state_n == HOLD)) begin
        out_data     <= best_n;
        out_index    <= idx_n;
        out_count    <= cnt_n;
        out_overflow <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_fp16_stream_extremum.sv
// Randomized self-checking bench: three parameterizations driven in lockstep,
// checked against a value-ordering reference model.
module tb_fp16_stream_extremum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, in_last, out_ready;
  logic [15:0] in_data;
  bit          bp_hold;

  logic        ready_a, ready_b, ready_c, vld_a, vld_b, vld_c;
  logic [15:0] data_a, data_b, data_c;
  logic [7:0]  idx_a, idx_b;
  logic [1:0]  idx_c;
  logic [8:0]  cnt_a, cnt_b;
  logic [2:0]  cnt_c;
  logic        ovf_a, ovf_b, ovf_c;

  int total = 0;
  int bad = 0;

  typedef struct { int data; int idx; int cnt; int ovf; } res_t;

  logic [15:0] cur[$];
  res_t        qa[$], qb[$], qc[$];
  int          nrel = 0;
  bit          exp_valid_next = 0;

  always #5 clk = ~clk;

  fp16_stream_extremum #(.DATA_WIDTH(16), .IDX_W(8), .FIND_MIN(0), .TIE_LAST(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_a), .in_data(in_data),
    .in_last(in_last), .out_valid(vld_a), .out_ready(out_ready), .out_data(data_a),
    .out_index(idx_a), .out_count(cnt_a), .out_overflow(ovf_a));

  fp16_stream_extremum #(.DATA_WIDTH(16), .IDX_W(8), .FIND_MIN(1), .TIE_LAST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_b), .in_data(in_data),
    .in_last(in_last), .out_valid(vld_b), .out_ready(out_ready), .out_data(data_b),
    .out_index(idx_b), .out_count(cnt_b), .out_overflow(ovf_b));

  fp16_stream_extremum #(.DATA_WIDTH(16), .IDX_W(2), .FIND_MIN(0), .TIE_LAST(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_c), .in_data(in_data),
    .in_last(in_last), .out_valid(vld_c), .out_ready(out_ready), .out_data(data_c),
    .out_index(idx_c), .out_count(cnt_c), .out_overflow(ovf_c));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Numeric rank: sign-magnitude as a signed integer, negatives shifted by one
  // so that -0 ranks just below +0.
  function automatic int okey(input logic [15:0] v);
    return v[15] ? -int'(v[14:0]) - 1 : int'(v[14:0]);
  endfunction

  function automatic res_t reduce(input logic [15:0] pk[$], input int idxw,
                                  input bit fmin, input bit tlast);
    res_t        r;
    logic [15:0] bv;
    int          cap, n, lim;
    cap = 1 << idxw;
    n   = pk.size();
    lim = (n < cap) ? n : cap;
    bv  = pk[0];
    r.idx = 0;
    r.cnt = lim;
    r.ovf = (n > cap) ? 1 : 0;
    for (int i = 1; i < lim; i++) begin
      if ((fmin ? okey(pk[i]) < okey(bv) : okey(pk[i]) > okey(bv)) ||
          (tlast && okey(pk[i]) == okey(bv))) begin
        bv    = pk[i];
        r.idx = i;
      end
    end
    r.data = int'(bv);
    return r;
  endfunction

  // Monitor, model and compare: everything sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_ready", int'({ready_a, ready_b, ready_c}), 0);
      chk("reset_valid", int'({vld_a, vld_b, vld_c}), 0);
      chk("reset_outs_a", int'(data_a) | int'(idx_a) | int'(cnt_a) | int'(ovf_a), 0);
      chk("reset_outs_bc", int'(data_b) | int'(idx_b) | int'(cnt_b) | int'(ovf_b) |
                           int'(data_c) | int'(idx_c) | int'(cnt_c) | int'(ovf_c), 0);
      cur.delete(); qa.delete(); qb.delete(); qc.delete();
      exp_valid_next = 0;
      nrel = 0;
    end else begin
      nrel++;
      if (exp_valid_next) chk("latency_valid", int'(vld_a), 1);
      exp_valid_next = 0;
      chk("ready_vs_valid", int'(ready_a), int'(nrel >= 2 && !vld_a));
      chk("lockstep", int'({ready_b, ready_c, vld_b, vld_c}), int'({ready_a, ready_a, vld_a, vld_a}));
      if (vld_a) begin
        if (qa.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("a_data", int'(data_a), qa[0].data);
          chk("a_index", int'(idx_a), qa[0].idx);
          chk("a_count", int'(cnt_a), qa[0].cnt);
          chk("a_ovf", int'(ovf_a), qa[0].ovf);
          chk("b_data", int'(data_b), qb[0].data);
          chk("b_index", int'(idx_b), qb[0].idx);
          chk("b_count", int'(cnt_b), qb[0].cnt);
          chk("b_ovf", int'(ovf_b), qb[0].ovf);
          chk("c_data", int'(data_c), qc[0].data);
          chk("c_index", int'(idx_c), qc[0].idx);
          chk("c_count", int'(cnt_c), qc[0].cnt);
          chk("c_ovf", int'(ovf_c), qc[0].ovf);
          if (out_ready) begin
            void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front());
          end
        end
      end
      if (in_valid && ready_a) begin
        cur.push_back(in_data);
        if (in_last) begin
          qa.push_back(reduce(cur, 8, 0, 0));
          qb.push_back(reduce(cur, 8, 1, 1));
          qc.push_back(reduce(cur, 2, 0, 0));
          cur.delete();
          exp_valid_next = 1;
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = bp_hold ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  task automatic send_beat(input logic [15:0] d, input bit last);
    bit done;
    done = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (ready_a) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    if (!done) chk("beat_accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] pk[$], input bit gaps);
    for (int i = 0; i < pk.size(); i++) begin
      send_beat(pk[i], i == pk.size() - 1);
      if (gaps && $urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (qa.size() == 0 && !vld_a && cur.size() == 0) done = 1;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    logic [15:0] p[$];
    logic [15:0] specials[8];
    res_t        r;
    bit          seen;
    specials = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'hFFFF, 16'h3C00, 16'hBC00};
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; bp_hold = 0;

    // Pin the reference model against hand-derived results.
    p = '{16'h3C00, 16'h4000, 16'hC000, 16'h3800};
    r = reduce(p, 8, 0, 0);
    chk("model_max_data", r.data, 'h4000); chk("model_max_idx", r.idx, 1); chk("model_max_cnt", r.cnt, 4);
    p = '{16'h0000, 16'h8000, 16'h0001};
    r = reduce(p, 8, 1, 1);
    chk("model_min_data", r.data, 'h8000); chk("model_min_idx", r.idx, 1);
    p = '{16'h4200, 16'h4200, 16'h4200};
    r = reduce(p, 8, 0, 0); chk("model_tie_first", r.idx, 0);
    r = reduce(p, 8, 1, 1); chk("model_tie_last", r.idx, 2);
    p = '{16'h3C00, 16'h4400, 16'h4200, 16'h3800, 16'h4000, 16'h5000};
    r = reduce(p, 2, 0, 0);
    chk("model_ovf_data", r.data, 'h4400); chk("model_ovf_idx", r.idx, 1);
    chk("model_ovf_cnt", r.cnt, 4); chk("model_ovf_flag", r.ovf, 1);

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    p = '{16'h3C00, 16'h4000, 16'hC000, 16'h3800}; send_pkt(p, 0);
    p = '{16'h0000, 16'h8000, 16'h0001};           send_pkt(p, 0);
    p = '{16'h4200, 16'h4200, 16'h4200};           send_pkt(p, 1);
    p = '{16'h3C00, 16'h4400, 16'h4200, 16'h3800, 16'h4000, 16'h5000}; send_pkt(p, 0);
    p = '{16'hBC00};                               send_pkt(p, 0);
    drain();

    // Backpressure: result held while a new beat is offered.
    bp_hold = 1;
    @(posedge clk); #1;
    p = '{16'h4400, 16'h3C00}; send_pkt(p, 0);
    in_valid = 1'b1; in_data = 16'h4800; in_last = 1'b1;
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (vld_a) seen = 1;
    end
    chk("bp_result_seen", int'(seen), 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_held", int'(vld_a), 1);
      chk("bp_data_held", int'(data_a), 'h4400);
      chk("bp_ready_low", int'(ready_a), 0);
    end
    @(posedge clk); #1;
    bp_hold = 0;
    send_beat(16'h4800, 1);
    drain();

    // Long packet overflows the 8-bit index configurations too.
    p.delete();
    for (int i = 0; i < 260; i++) p.push_back(16'($urandom));
    send_pkt(p, 0);
    drain();

    for (int k = 0; k < 40; k++) begin
      int len;
      len = $urandom_range(1, 12);
      p.delete();
      for (int i = 0; i < len; i++) begin
        if (i > 0 && $urandom_range(4) == 0) p.push_back(p[i-1]);
        else if ($urandom_range(3) == 0) p.push_back(specials[$urandom_range(0, 7)]);
        else p.push_back(16'($urandom));
      end
      send_pkt(p, 1);
    end
    drain();

    // Reset while beat 2 of a packet is being offered.
    send_beat(16'h3C00, 0);
    send_beat(16'h4000, 0);
    in_valid = 1'b1; in_data = 16'h4400; in_last = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; in_valid = 1'b0;
    p = '{16'hBC00}; send_pkt(p, 0);
    drain();

    chk("queues_empty", qa.size() + qb.size() + qc.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp16_stream_extremum.md
Name: fp16_stream_extremum

Overview:
- Streaming reduction unit. Consumes a packet of FP16 values over a valid/ready handshake and tracks the running maximum (or minimum) and its position.
- Emits one result beat per packet: extremum value, index and element count.
- Sits downstream of the annealing energy datapath and selects the best candidate from a batch of evaluated states.
- Performs the ordering decision sequentially, one comparison per accepted beat.

Parameters:
- DATA_WIDTH, 16, operand width; only 16 (binary16 layout: sign[15], exp[14:10], mant[9:0]) is supported.
- IDX_W, 8, width of the index and count fields; maximum packet length is 2^IDX_W.
- FIND_MIN, 0, 0 = track maximum, 1 = track minimum.
- TIE_LAST, 0, 0 = on equal values keep the earliest index, 1 = replace with the latest index.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept an input beat.
- in_data  in  DATA_WIDTH  FP16 operand.
- in_last  in  1  final beat of the packet.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_WIDTH  extremum value.
- out_index  out  IDX_W  zero-based index of the extremum within the packet.
- out_count  out  IDX_W+1  number of beats in the packet.
- out_overflow  out  1  packet exceeded 2^IDX_W beats.

Behaviour:
- Reset: all outputs are 0, state is EMPTY, in_ready=0 during reset and 1 from the first clock after release.
- Ordering is a total order on sign-magnitude:
  - Positive values beat negative values.
  - Among positives, the larger {exp,mant} wins; among negatives, the smaller {exp,mant} wins.
  - +0 > -0; identical bit patterns are equal.
  - NaN/Inf are ordered by bit pattern under the same rule; no special handling.
- "Better" means strictly greater for max mode or strictly less for min mode. When TIE_LAST=1, equal also counts as better.
- Handshake: a beat transfers when in_valid && in_ready; a result transfers when out_valid && out_ready.
- State EMPTY (in_ready=1, out_valid=0):
  - On transfer, load best=in_data, best_idx=0, cnt=1, ovf=0.
  - If in_last is set, go to HOLD; otherwise go to ACCUM.
- State ACCUM (in_ready=1, out_valid=0):
  - On transfer, if in_data is better than best, set best=in_data and best_idx=cnt[IDX_W-1:0].
  - Increment cnt. When cnt reaches 2^IDX_W, further beats set ovf=1, saturate cnt, and stop updating best/best_idx; comparison is suppressed.
  - If in_last is set, go to HOLD.
- State HOLD (in_ready=0, out_valid=1):
  - out_data/out_index/out_count/out_overflow are driven from the registers and stay stable until out_ready.
  - On transfer, go to EMPTY.
  - No input is accepted in the handoff cycle; the earliest next beat is accepted one cycle later.
- Latency: out_valid rises on the clock edge that accepts the in_last beat and is visible in the following cycle, so a 1-beat packet yields its result 1 cycle after acceptance.
- Throughput: one beat per cycle in ACCUM, plus at least one HOLD cycle per packet.
- in_data, in_last and in_valid are don't-care when no transfer occurs.
- out_* hold their last values outside HOLD; only out_valid qualifies them.
- The comparator is combinational on in_data against the best register. The best register, index and state update together on the same edge.
- Asynchronous reset mid-packet or in HOLD discards the packet immediately. All outputs go to 0 and no partial result is emitted.

Test Plan:
- Max, packet {0x3C00 (1.0), 0x4000 (2.0), 0xC000 (-2.0), 0x3800 (0.5)} with last on beat 3 -> out_data=0x4000, out_index=1, out_count=4, out_overflow=0, out_valid one cycle after the last beat.
- FIND_MIN=1, packet {0x0000 (+0), 0x8000 (-0), 0x0001} -> out_data=0x8000, out_index=1, out_count=3.
- Ties, packet {0x4200, 0x4200, 0x4200}: TIE_LAST=0 -> out_index=0; TIE_LAST=1 -> out_index=2.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> out_valid stays 1 with stable out_data, in_ready=0 throughout, and a new packet offered meanwhile is not accepted until 1 cycle after the result transfers.
- IDX_W=2, 6-beat packet with the maximum 0x5000 at beat 5 -> out_overflow=1, out_count=4, out_index is the best among the first 4 beats, and 0x5000 is ignored.
- Drive rst_n low during beat 2 of a packet, then send the 1-beat packet {0xBC00} -> outputs are 0 during reset; after reset the result is out_data=0xBC00, out_index=0, out_count=1.
